// File: rtl/pwm_carrier_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_carrier_scheduler_pkg
//  Description : Shared constants for the PWM carrier scheduler, the PWM legs
//                and the host-register decoder (data width, state encoding).
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_carrier_scheduler_pkg;

    // Width of every period and duty word on the carrier bus.
    localparam int unsigned c_DATA_W = 16;

    // Sequencer state encoding, also exposed on state_o.
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ARM   = 2'd1;
    localparam logic [1:0] c_ST_RUN   = 2'd2;
    localparam logic [1:0] c_ST_FAULT = 2'd3;

endpackage : pwm_carrier_scheduler_pkg
`default_nettype wire

// File: rtl/pwm_carrier_scheduler_shadow_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_shadow_reg
//  Description : Generic double-buffered register. A write strobe loads the
//                staging copy; a transfer strobe copies staging into the
//                active copy seen by downstream logic.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_shadow_reg
    import pwm_carrier_scheduler_pkg::*;
#(
    parameter int unsigned      WIDTH     = c_DATA_W,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_xfer,
    output logic [WIDTH-1:0] o_shadow,
    output logic [WIDTH-1:0] o_active
);

    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_active;

    // Staging and active copies; a write on the transfer cycle is held for
    // the following transfer because active samples the old staging value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= RESET_VAL;
            r_active <= RESET_VAL;
        end else begin
            if (i_wr) begin
                r_shadow <= i_wr_data;
            end
            if (i_xfer) begin
                r_active <= r_shadow;
            end
        end
    end

    assign o_shadow = r_shadow;
    assign o_active = r_active;

endmodule : pwm_shadow_reg
`default_nettype wire

// File: rtl/pwm_carrier_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_carrier_scheduler
//  Description : Shared carrier counter, half-period phase flag, double-
//                buffered period/duty words and the common output-enable
//                sequencer (IDLE/ARM/RUN/FAULT) for a bank of symmetrical
//                PWM legs.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_carrier_scheduler
    import pwm_carrier_scheduler_pkg::*;
#(
    parameter int unsigned         N_CH         = 3,
    parameter logic [c_DATA_W-1:0] MIN_PERIOD   = 16'd100,
    parameter logic [c_DATA_W-1:0] RESET_PERIOD = 16'd1000
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [c_DATA_W-1:0]        period_i,
    input  logic                       period_wr_i,
    input  logic [c_DATA_W*N_CH-1:0]   duty_i,
    input  logic                       duty_wr_i,
    input  logic                       start_i,
    input  logic                       stop_i,
    input  logic                       fault_i,
    input  logic                       fault_clr_i,
    output logic [c_DATA_W-1:0]        local_counter_o,
    output logic                       sync_phase_o,
    output logic [c_DATA_W-1:0]        current_period_o,
    output logic [c_DATA_W-1:0]        next_period_o,
    output logic [c_DATA_W*N_CH-1:0]   duty_o,
    output logic                       enable_output_o,
    output logic [1:0]                 state_o,
    output logic                       boundary_o,
    output logic                       period_err_o
);

    // ------------------------------------------------------------------
    // Carrier counter state
    // ------------------------------------------------------------------
    logic [c_DATA_W-1:0] r_counter;
    logic                r_phase;
    logic                r_boundary;
    logic                r_period_err;

    logic [c_DATA_W-1:0] w_cur_period;
    logic [c_DATA_W-1:0] w_next_period;
    logic                w_wrap;
    logic [c_DATA_W-1:0] w_cnt_nxt;
    logic                w_phase_nxt;
    logic [c_DATA_W-1:0] w_cur_nxt;
    logic                w_bnd_nxt;
    logic                w_period_ok;

    // Sequencer state
    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_stop_pend;
    logic       w_stop_pend_nxt;
    logic       r_enable;

    // Staging copies of the duties are only needed inside the shadow regs.
    logic [c_DATA_W*N_CH-1:0] w_unused_duty_stage;

    // Next-cycle counter, phase and boundary; the boundary flag is computed
    // one cycle ahead so boundary_o can be a plain register. The >= compare
    // keeps the counter from overrunning if the period ever shrinks.
    always_comb begin
        w_period_ok = (period_i >= MIN_PERIOD);
        w_wrap      = (r_counter >= (w_cur_period - 16'd1));
        w_cnt_nxt   = w_wrap ? '0 : (r_counter + 16'd1);
        w_phase_nxt = r_phase ^ w_wrap;
        w_cur_nxt   = r_boundary ? w_next_period : w_cur_period;
        w_bnd_nxt   = w_phase_nxt && (w_cnt_nxt >= (w_cur_nxt - 16'd1));
    end

    // Carrier counter, phase, boundary pulse and period-reject pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_counter    <= '0;
            r_phase      <= 1'b0;
            r_boundary   <= 1'b0;
            r_period_err <= 1'b0;
        end else begin
            r_counter    <= w_cnt_nxt;
            r_phase      <= w_phase_nxt;
            r_boundary   <= w_bnd_nxt;
            r_period_err <= period_wr_i && !w_period_ok;
        end
    end

    // Period: staging is next_period_o, active is current_period_o, copied
    // on the boundary cycle so the new period starts at counter 0, phase 0.
    pwm_shadow_reg #(
        .WIDTH     (c_DATA_W),
        .RESET_VAL (RESET_PERIOD)
    ) u_period_shadow (
        .clk       (clk_i),
        .rst       (rst_i),
        .i_wr      (period_wr_i && w_period_ok),
        .i_wr_data (period_i),
        .i_xfer    (r_boundary),
        .o_shadow  (w_next_period),
        .o_active  (w_cur_period)
    );

    // Duties: transferred whenever the phase toggles, so each half-carrier
    // sees one stable duty word per leg.
    genvar k;
    generate
        for (k = 0; k < N_CH; k++) begin : g_duty
            pwm_shadow_reg #(
                .WIDTH     (c_DATA_W),
                .RESET_VAL ('0)
            ) u_duty_shadow (
                .clk       (clk_i),
                .rst       (rst_i),
                .i_wr      (duty_wr_i),
                .i_wr_data (duty_i[k*c_DATA_W +: c_DATA_W]),
                .i_xfer    (w_wrap),
                .o_shadow  (w_unused_duty_stage[k*c_DATA_W +: c_DATA_W]),
                .o_active  (duty_o[k*c_DATA_W +: c_DATA_W])
            );
        end
    endgenerate

    // Sequencer next state; fault dominates start, stop and boundary.
    always_comb begin
        w_state_nxt     = r_state;
        w_stop_pend_nxt = r_stop_pend;
        if (fault_i) begin
            w_state_nxt     = c_ST_FAULT;
            w_stop_pend_nxt = 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    w_stop_pend_nxt = 1'b0;
                    if (start_i && !stop_i) begin
                        w_state_nxt = c_ST_ARM;
                    end
                end
                c_ST_ARM: begin
                    if (stop_i) begin
                        w_state_nxt = c_ST_IDLE;
                    end else if (r_boundary) begin
                        w_state_nxt = c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    if (r_boundary && (r_stop_pend || stop_i)) begin
                        w_state_nxt     = c_ST_IDLE;
                        w_stop_pend_nxt = 1'b0;
                    end else if (stop_i) begin
                        w_stop_pend_nxt = 1'b1;
                    end
                end
                c_ST_FAULT: begin
                    w_stop_pend_nxt = 1'b0;
                    if (fault_clr_i) begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt     = c_ST_IDLE;
                    w_stop_pend_nxt = 1'b0;
                end
            endcase
        end
    end

    // Sequencer registers; enable is decoded from the next state so it
    // lines up with the state it belongs to.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= c_ST_IDLE;
            r_stop_pend <= 1'b0;
            r_enable    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_stop_pend <= w_stop_pend_nxt;
            r_enable    <= (w_state_nxt == c_ST_RUN);
        end
    end

    assign local_counter_o  = r_counter;
    assign sync_phase_o     = r_phase;
    assign current_period_o = w_cur_period;
    assign next_period_o    = w_next_period;
    assign enable_output_o  = r_enable;
    assign state_o          = r_state;
    assign boundary_o       = r_boundary;
    assign period_err_o     = r_period_err;

endmodule : pwm_carrier_scheduler
`default_nettype wire

// File: tb/tb_pwm_carrier_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_carrier_scheduler
//  Description : Scoreboard bench for pwm_carrier_scheduler. Stimulus pushes
//                hand-computed output events; a monitor pops and compares
//                whenever the DUT shows a boundary, reject pulse or a change
//                of enable, state, period or duty.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_carrier_scheduler;

    localparam int K_B = 0;  // boundary pulse
    localparam int K_P = 1;  // period reject pulse
    localparam int K_E = 2;  // enable change
    localparam int K_S = 3;  // state change
    localparam int K_C = 4;  // current period change
    localparam int K_N = 5;  // next period change
    localparam int K_D = 6;  // duty change

    localparam int IDLE = 0, ARM = 1, RUN = 2, FLT = 3;

    localparam logic [47:0] D0 = 48'd0;
    localparam logic [47:0] D1 = {16'd500, 16'd400, 16'd300};
    localparam logic [47:0] D2 = {16'd3, 16'd2, 16'd1};

    typedef struct {
        int          kind;
        int          t;
        int          cnt;
        int          ph;
        int          st;
        int          en;
        int          cur;
        int          nxt;
        logic [47:0] duty;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] period_i = '0;
    logic        period_wr_i = 1'b0;
    logic [47:0] duty_i = '0;
    logic        duty_wr_i = 1'b0;
    logic        start_i = 1'b0;
    logic        stop_i = 1'b0;
    logic        fault_i = 1'b0;
    logic        fault_clr_i = 1'b0;

    logic [15:0] local_counter_o;
    logic        sync_phase_o;
    logic [15:0] current_period_o;
    logic [15:0] next_period_o;
    logic [47:0] duty_o;
    logic        enable_output_o;
    logic [1:0]  state_o;
    logic        boundary_o;
    logic        period_err_o;

    ev_t sb_q[$];
    int  n_total = 0;
    int  n_pass  = 0;
    int  t_cnt   = 0;
    bit  mon_en  = 1'b0;

    logic        p_en;
    logic [1:0]  p_st;
    logic [15:0] p_cur;
    logic [15:0] p_nxt;
    logic [47:0] p_duty;

    pwm_carrier_scheduler #(
        .N_CH         (3),
        .MIN_PERIOD   (16'd100),
        .RESET_PERIOD (16'd1000)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .period_i         (period_i),
        .period_wr_i      (period_wr_i),
        .duty_i           (duty_i),
        .duty_wr_i        (duty_wr_i),
        .start_i          (start_i),
        .stop_i           (stop_i),
        .fault_i          (fault_i),
        .fault_clr_i      (fault_clr_i),
        .local_counter_o  (local_counter_o),
        .sync_phase_o     (sync_phase_o),
        .current_period_o (current_period_o),
        .next_period_o    (next_period_o),
        .duty_o           (duty_o),
        .enable_output_o  (enable_output_o),
        .state_o          (state_o),
        .boundary_o       (boundary_o),
        .period_err_o     (period_err_o)
    );

    always #5 clk = ~clk;

    // Cycle index since the last reset release; cycle 0 shows counter 0.
    always @(posedge clk) begin
        if (rst_i) t_cnt <= 0;
        else       t_cnt <= t_cnt + 1;
    end

    task automatic push(input int k, input int t, input int cnt, input int ph,
                        input int st, input int en, input int cur, input int nxt,
                        input logic [47:0] d);
        ev_t e;
        e.kind = k; e.t = t; e.cnt = cnt; e.ph = ph; e.st = st;
        e.en = en; e.cur = cur; e.nxt = nxt; e.duty = d;
        sb_q.push_back(e);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic waitt(input int n);
        while (t_cnt < n) @(negedge clk);
    endtask

    task automatic mon_evt(input int k);
        ev_t e;
        n_total++;
        if (sb_q.size() == 0) begin
            $display("FAIL unexpected_event: kind=%0d t=%0d cnt=%0d ph=%0d st=%0d, expected no event",
                     k, t_cnt, local_counter_o, sync_phase_o, state_o);
        end else begin
            e = sb_q.pop_front();
            if (e.kind == k && e.t == t_cnt && e.cnt == int'(local_counter_o) &&
                e.ph == int'(sync_phase_o) && e.st == int'(state_o) &&
                e.en == int'(enable_output_o) && e.cur == int'(current_period_o) &&
                e.nxt == int'(next_period_o) && e.duty == duty_o) begin
                n_pass++;
            end else begin
                $display("FAIL event: got kind=%0d t=%0d cnt=%0d ph=%0d st=%0d en=%0d cur=%0d nxt=%0d duty=%h, expected kind=%0d t=%0d cnt=%0d ph=%0d st=%0d en=%0d cur=%0d nxt=%0d duty=%h",
                         k, t_cnt, local_counter_o, sync_phase_o, state_o, enable_output_o,
                         current_period_o, next_period_o, duty_o,
                         e.kind, e.t, e.cnt, e.ph, e.st, e.en, e.cur, e.nxt, e.duty);
            end
        end
    endtask

    // Monitor: every observable event pops one scoreboard entry.
    always @(negedge clk) begin
        if (mon_en) begin
            if (boundary_o)                 mon_evt(K_B);
            if (period_err_o)               mon_evt(K_P);
            if (enable_output_o != p_en)    mon_evt(K_E);
            if (state_o != p_st)            mon_evt(K_S);
            if (current_period_o != p_cur)  mon_evt(K_C);
            if (next_period_o != p_nxt)     mon_evt(K_N);
            if (duty_o != p_duty)           mon_evt(K_D);
        end
        p_en   = enable_output_o;
        p_st   = state_o;
        p_cur  = current_period_o;
        p_nxt  = next_period_o;
        p_duty = duty_o;
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_counter", int'(local_counter_o), 0);
        chk("rst_phase",   int'(sync_phase_o), 0);
        chk("rst_cur",     int'(current_period_o), 1000);
        chk("rst_next",    int'(next_period_o), 1000);
        chk("rst_duty",    int'(duty_o != 48'd0), 0);
        chk("rst_en_st",   int'({enable_output_o, state_o}), 0);
        chk("rst_pulses",  int'({boundary_o, period_err_o}), 0);

        mon_en = 1'b1;
        rst_i  = 1'b0;
        push(K_B, 1999, 999, 1, IDLE, 0, 1000, 1000, D0);

        // Start mid first half: arm, then run from the next carrier.
        waitt(2500);
        start_i = 1'b1;
        push(K_S, 2501, 501, 0, ARM, 0, 1000, 1000, D0);
        push(K_B, 3999, 999, 1, ARM, 0, 1000, 1000, D0);
        push(K_E, 4000, 0, 0, RUN, 1, 1000, 1000, D0);
        push(K_S, 4000, 0, 0, RUN, 1, 1000, 1000, D0);
        @(negedge clk);
        start_i = 1'b0;

        // Accepted period write, then a rejected one.
        waitt(4300);
        period_i = 16'd200; period_wr_i = 1'b1;
        push(K_N, 4301, 301, 0, RUN, 1, 1000, 200, D0);
        @(negedge clk);
        period_wr_i = 1'b0;
        waitt(4310);
        period_i = 16'd50; period_wr_i = 1'b1;
        push(K_P, 4311, 311, 0, RUN, 1, 1000, 200, D0);
        push(K_B, 5999, 999, 1, RUN, 1, 1000, 200, D0);
        push(K_C, 6000, 0, 0, RUN, 1, 200, 200, D0);
        @(negedge clk);
        period_wr_i = 1'b0;

        // Duty write mid-half lands at the next toggle.
        waitt(6010);
        duty_i = D1; duty_wr_i = 1'b1;
        push(K_D, 6200, 0, 1, RUN, 1, 200, 200, D1);
        push(K_B, 6399, 199, 1, RUN, 1, 200, 200, D1);
        @(negedge clk);
        duty_wr_i = 1'b0;

        // Duty write on the toggle cycle waits for the following toggle.
        waitt(6599);
        duty_i = D2; duty_wr_i = 1'b1;
        push(K_B, 6799, 199, 1, RUN, 1, 200, 200, D1);
        push(K_D, 6800, 0, 0, RUN, 1, 200, 200, D2);
        @(negedge clk);
        duty_wr_i = 1'b0;

        // Stop is deferred to the carrier boundary.
        waitt(6900);
        stop_i = 1'b1;
        push(K_B, 7199, 199, 1, RUN, 1, 200, 200, D2);
        push(K_E, 7200, 0, 0, IDLE, 0, 200, 200, D2);
        push(K_S, 7200, 0, 0, IDLE, 0, 200, 200, D2);
        @(negedge clk);
        stop_i = 1'b0;

        // Restart, then fault together with stop on a boundary.
        waitt(7300);
        start_i = 1'b1;
        push(K_S, 7301, 101, 0, ARM, 0, 200, 200, D2);
        push(K_B, 7599, 199, 1, ARM, 0, 200, 200, D2);
        push(K_E, 7600, 0, 0, RUN, 1, 200, 200, D2);
        push(K_S, 7600, 0, 0, RUN, 1, 200, 200, D2);
        push(K_B, 7999, 199, 1, RUN, 1, 200, 200, D2);
        @(negedge clk);
        start_i = 1'b0;

        waitt(7999);
        fault_i = 1'b1; stop_i = 1'b1;
        push(K_E, 8000, 0, 0, FLT, 0, 200, 200, D2);
        push(K_S, 8000, 0, 0, FLT, 0, 200, 200, D2);
        @(negedge clk);
        stop_i = 1'b0;

        // Clear while the fault is still present must be ignored.
        waitt(8050);
        fault_clr_i = 1'b1;
        @(negedge clk);
        fault_clr_i = 1'b0;
        waitt(8100);
        fault_i = 1'b0;
        waitt(8150);
        fault_clr_i = 1'b1;
        push(K_S, 8151, 151, 0, IDLE, 0, 200, 200, D2);
        @(negedge clk);
        fault_clr_i = 1'b0;

        waitt(8300);
        chk("sb_drain", sb_q.size(), 0);

        // Mid-carrier reset returns everything to reset values.
        mon_en = 1'b0;
        rst_i  = 1'b1;
        @(negedge clk);
        chk("mrst_counter", int'(local_counter_o), 0);
        chk("mrst_phase",   int'(sync_phase_o), 0);
        chk("mrst_periods", int'({current_period_o, next_period_o}), int'({16'd1000, 16'd1000}));
        chk("mrst_duty",    int'(duty_o != 48'd0), 0);
        chk("mrst_state",   int'({enable_output_o, state_o}), 0);
        rst_i = 1'b0;

        // Staging duties were cleared: the next toggle must still load zero.
        waitt(1000);
        chk("post_phase",   int'(sync_phase_o), 1);
        chk("post_counter", int'(local_counter_o), 0);
        chk("post_duty",    int'(duty_o != 48'd0), 0);
        chk("post_next",    int'(next_period_o), 1000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_pwm_carrier_scheduler
`default_nettype wire

// File: doc/pwm_carrier_scheduler.md
# pwm_carrier_scheduler

Central carrier and sequencing controller for a bank of symmetrical-PWM legs. It generates the shared carrier counter, the half-period phase flag, and the current/next period words that every PWM leg consumes. It double-buffers period and per-leg duty writes so that they take effect only at carrier boundaries. It also sequences the common output-enable through idle, arm, run and fault states, so legs start and stop on whole carrier periods.

## Interface
Parameters:
- N_CH, 3, number of PWM legs served
- MIN_PERIOD, 16'd100, smallest accepted period (half-carrier length in clocks)
- RESET_PERIOD, 16'd1000, period loaded on reset

Ports:
- clk_i  in  1  system clock, single clock domain
- rst_i  in  1  synchronous reset, active-high
- period_i  in  16  requested period
- period_wr_i  in  1  one-cycle write strobe for period_i
- duty_i  in  16*N_CH  requested duties, leg k at [16k+15:16k]
- duty_wr_i  in  1  one-cycle write strobe for all duties
- start_i  in  1  request start (level sampled)
- stop_i  in  1  request stop (level sampled)
- fault_i  in  1  external fault, level
- fault_clr_i  in  1  clear latched fault
- local_counter_o  out  16  carrier counter, 0..current_period_o-1
- sync_phase_o  out  1  carrier half; 0 = first half, 1 = second half
- current_period_o  out  16  period in force this carrier
- next_period_o  out  16  shadow period, applied at next boundary
- duty_o  out  16*N_CH  duties presented to legs
- enable_output_o  out  1  common PWM output enable
- state_o  out  2  IDLE=0, ARM=1, RUN=2, FAULT=3
- boundary_o  out  1  one-cycle pulse on the last cycle of a full carrier
- period_err_o  out  1  one-cycle pulse when a period write is rejected

## Operation
- Counter runs in every state except during reset.
  - Increments each clock.
  - At current_period_o-1 it wraps to 0 and toggles sync_phase_o.
- Boundary: local_counter_o==current_period_o-1 and sync_phase_o==1.
  - On the next cycle, current_period_o takes next_period_o.
- Period write:
  - If period_i>=MIN_PERIOD, next_period_o<=period_i.
  - Otherwise the write is ignored and period_err_o pulses.
  - The last write before a boundary wins.
- Duty write:
  - A staging register captures duty_i.
  - duty_o loads the staging register on the cycle sync_phase_o toggles, so every half-carrier sees a stable duty.
  - A write coinciding with the toggle cycle lands at the following toggle.
- State machine:
  - IDLE: enable 0. start_i && !stop_i -> ARM.
  - ARM: enable 0. On boundary -> RUN. stop_i -> IDLE.
  - RUN: enable 1. stop_i sets a pending-stop flag; on the next boundary -> IDLE and the flag clears.
  - FAULT: enable 0. fault_clr_i && !fault_i -> IDLE.
  - fault_i in any state -> FAULT. Fault has priority over start, stop and boundary.
- Reset values:
  - local_counter_o=0, sync_phase_o=0.
  - current_period_o=next_period_o=RESET_PERIOD.
  - duty_o=0 and staging duties=0.
  - enable_output_o=0, state_o=IDLE, boundary_o=0, period_err_o=0.

## Timing
- All outputs are registered.
- enable_output_o = (state==RUN), registered.
  - Rises 1 cycle after the boundary that moves ARM->RUN, i.e. together with counter=0, phase=0.
  - Falls 1 cycle after a fault_i sample, or together with counter=0 after a stop boundary.
- current_period_o changes on exactly the cycle counter=0, phase=0 follows a boundary.
- Period write to next_period_o latency is 1 cycle.
- rst_i mid-carrier: next cycle, all values are at reset values; the pending stop flag and staging registers are cleared.
- Counter comparison uses 16-bit unsigned arithmetic. If current_period_o changes, wrap is detected with >= current_period_o-1, so it never overruns.

## Structure
- Shared package: the state encoding constants (IDLE/ARM/RUN/FAULT) and the 16-bit period/duty width constant, reused by the PWM legs and host-register decoder.
- One natural sub-module, pwm_shadow_reg: a generic width-parameterised write-staging register plus transfer-on-strobe register, instantiated for the period and for each duty.

## Test plan
- Reset, then 3×RESET_PERIOD cycles idle -> counter sweeps 0..999 twice per carrier, boundary_o every 2000 cycles, enable 0.
- start_i at counter=500, phase 0 -> ARM; enable rises on the cycle counter=0, phase 0 following the first boundary (1499 cycles after start sample + 1).
- period_wr_i with 200 mid-carrier, then 50 -> 200 applied at next boundary; 50 rejected with period_err_o pulse; next_period_o stays 200.
- duty_wr_i with leg0=300 at counter=10, phase 0 -> duty_o[15:0]=300 from the phase-1 toggle cycle, unchanged mid-half.
- RUN, stop_i at counter=100, phase 0 -> enable held until boundary, falls with counter=0; state IDLE.
- RUN, fault_i asserted together with stop_i and boundary -> state FAULT, enable 0 next cycle; fault_clr_i while fault_i=1 ignored; after fault_i=0, fault_clr_i -> IDLE.
